// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bundle: global enable, icache request/response, issue head, flush redirect and occupancy.
// master modport is the fetch queue itself; slave modport is its environment (icache, issue, control).
// Widths follow the instantiating parameters; count_out is $clog2(DEPTH)+1 bits wide.
interface if_fetch_queue_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 8
);
    logic                     rdy_in;
    logic                     icache_req_valid_out;
    logic [ADDR_WIDTH-1:0]    icache_req_addr_out;
    logic                     icache_req_ready_in;
    logic                     icache_resp_valid_in;
    logic [INSTR_WIDTH-1:0]   icache_resp_instr_in;
    logic                     issue_valid_out;
    logic [INSTR_WIDTH-1:0]   issue_instr_out;
    logic [ADDR_WIDTH-1:0]    issue_pc_out;
    logic                     issue_ready_in;
    logic                     flush_in;
    logic [ADDR_WIDTH-1:0]    flush_pc_in;
    logic [$clog2(DEPTH):0]   count_out;

    modport master (
        input  rdy_in,
        output icache_req_valid_out, icache_req_addr_out,
        input  icache_req_ready_in, icache_resp_valid_in, icache_resp_instr_in,
        output issue_valid_out, issue_instr_out, issue_pc_out,
        input  issue_ready_in, flush_in, flush_pc_in,
        output count_out
    );

    modport slave (
        output rdy_in,
        input  icache_req_valid_out, icache_req_addr_out,
        output icache_req_ready_in, icache_resp_valid_in, icache_resp_instr_in,
        input  issue_valid_out, issue_instr_out, issue_pc_out,
        output issue_ready_in, flush_in, flush_pc_in,
        input  count_out
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one word fetch at a time, queues {instr, pc} for issue.
// Latency: response pushed on the edge it arrives; show-ahead head visible the cycle after the push.
// Backpressure: never requests unless the push would fit; issue_ready_in pops the head; rdy_in=0 freezes all but flush.
// Ports: clk_in, rst_in (async, active-high), bus (if_fetch_queue_if.master: icache, issue, flush, rdy_in, count_out).
module if_fetch_queue #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    DEPTH       = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic               clk_in,
    input  logic               rst_in,
    if_fetch_queue_if.master   bus
);
    localparam int            PW      = $clog2(DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  fetch_pc_q;
    logic [PW-1:0]          head_q, tail_q;
    logic [PW:0]            count_q;
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];

    logic                   req_acc, push, pop;
    logic [PW:0]            count_after_pop, count_next;
    logic [ADDR_WIDTH-1:0]  flush_pc_aligned;

    // Flush outranks every same-cycle push/pop, so both are masked by it.
    assign pop     = bus.rdy_in && !bus.flush_in && (count_q != '0) && bus.issue_ready_in;
    assign req_acc = bus.rdy_in && (state_q == REQ) && bus.icache_req_ready_in;
    assign push    = bus.rdy_in && !bus.flush_in && (state_q == WAIT) && bus.icache_resp_valid_in;

    assign count_after_pop  = count_q - {{PW{1'b0}}, pop};
    assign count_next       = count_after_pop + {{PW{1'b0}}, push};
    assign flush_pc_aligned = bus.flush_pc_in & ~ADDR_WIDTH'(3);

    // State register and FIFO pointers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            if (bus.flush_in) begin
                head_q     <= '0;
                tail_q     <= '0;
                count_q    <= '0;
                fetch_pc_q <= flush_pc_aligned;
            end else begin
                if (push) begin
                    tail_q     <= tail_q + 1'b1;
                    fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(4);
                end
                if (pop) begin
                    head_q <= head_q + 1'b1;
                end
                count_q <= count_next;
            end
        end
    end

    // Entry storage carries no reset; the head is masked while the queue is empty.
    always_ff @(posedge clk_in) begin
        if (push) begin
            instr_mem[tail_q] <= bus.icache_resp_instr_in;
            pc_mem[tail_q]    <= fetch_pc_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (bus.flush_in) begin
            case (state_q)
                // An accepted request still owes a response that must be swallowed.
                REQ:     state_d = req_acc ? DISCARD : IDLE;
                // A response landing with the flush is dropped here, nothing left outstanding.
                WAIT:    state_d = bus.icache_resp_valid_in ? IDLE : DISCARD;
                DISCARD: state_d = bus.icache_resp_valid_in ? IDLE : DISCARD;
                default: state_d = IDLE;
            endcase
        end else if (bus.rdy_in) begin
            case (state_q)
                IDLE:    if (count_after_pop < DEPTH_C) state_d = REQ;
                REQ:     if (req_acc) state_d = WAIT;
                WAIT:    if (bus.icache_resp_valid_in) state_d = (count_next < DEPTH_C) ? REQ : IDLE;
                DISCARD: if (bus.icache_resp_valid_in) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        bus.icache_req_valid_out = (state_q == REQ);
        bus.icache_req_addr_out  = fetch_pc_q;
        bus.issue_valid_out      = (count_q != '0);
        bus.issue_instr_out      = '0;
        bus.issue_pc_out         = '0;
        if (count_q != '0) begin
            bus.issue_instr_out = instr_mem[head_q];
            bus.issue_pc_out    = pc_mem[head_q];
        end
        bus.count_out = count_q;
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic clk = 1'b0;
    logic rst1, rst2;
    always #5 clk = ~clk;

    if_fetch_queue_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4)) bus1();
    if_fetch_queue_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4)) bus2();

    if_fetch_queue #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000))
        dut1 (.clk_in(clk), .rst_in(rst1), .bus(bus1));
    if_fetch_queue #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC))
        dut2 (.clk_in(clk), .rst_in(rst2), .bus(bus2));

    ent_t exp1[$];
    ent_t exp2[$];
    int   tests = 0;
    int   fails = 0;
    int   resp_delay = 1;

    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic push1(input logic [31:0] pc);
        exp1.push_back({pc, ins_of(pc)});
    endtask

    task automatic push2(input logic [31:0] pc);
        exp2.push_back({pc, ins_of(pc)});
    endtask

    // Scoreboard monitor: compares every issued head against the expected queue.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (!rst1 && bus1.issue_valid_out && bus1.issue_ready_in && bus1.rdy_in && !bus1.flush_in) begin
                if (exp1.size() == 0) tmo("dut1 unexpected issue");
                else begin
                    e = exp1.pop_front();
                    chk("dut1 issue pc", {32'h0, bus1.issue_pc_out}, {32'h0, e.pc});
                    chk("dut1 issue instr", {32'h0, bus1.issue_instr_out}, {32'h0, e.instr});
                end
            end
            if (!rst2 && bus2.issue_valid_out && bus2.issue_ready_in && bus2.rdy_in && !bus2.flush_in) begin
                if (exp2.size() == 0) tmo("dut2 unexpected issue");
                else begin
                    e = exp2.pop_front();
                    chk("dut2 issue pc", {32'h0, bus2.issue_pc_out}, {32'h0, e.pc});
                    chk("dut2 issue instr", {32'h0, bus2.issue_instr_out}, {32'h0, e.instr});
                end
            end
        end
    end

    // Issue side takes entries only while expectations are outstanding.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus1.issue_ready_in = (exp1.size() != 0);
            bus2.issue_ready_in = (exp2.size() != 0);
        end
    end

    // Icache model for dut1: response resp_delay cycles after accept, frozen while rdy_in=0.
    int          cd1 = 0;
    logic [31:0] pend1, a1;
    logic        acc1, go1;
    initial begin
        bus1.icache_resp_valid_in = 1'b0;
        bus1.icache_resp_instr_in = '0;
        forever begin
            @(negedge clk);
            acc1 = bus1.icache_req_valid_out && bus1.icache_req_ready_in && bus1.rdy_in;
            a1   = bus1.icache_req_addr_out;
            go1  = bus1.rdy_in;
            @(posedge clk);
            #1;
            bus1.icache_resp_valid_in = 1'b0;
            if (rst1) cd1 = 0;
            else begin
                if (cd1 > 0 && go1) begin
                    cd1--;
                    if (cd1 == 0) begin
                        bus1.icache_resp_valid_in = 1'b1;
                        bus1.icache_resp_instr_in = ins_of(pend1);
                    end
                end
                if (acc1) begin
                    pend1 = a1;
                    cd1   = resp_delay - 1;
                    if (cd1 == 0) begin
                        bus1.icache_resp_valid_in = 1'b1;
                        bus1.icache_resp_instr_in = ins_of(a1);
                    end
                end
            end
        end
    end

    task automatic wait_req1(input string name);
        int n = 0;
        @(negedge clk);
        while (!bus1.icache_req_valid_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus1.icache_req_valid_out) tmo(name);
    endtask

    task automatic drain1(input string name);
        int n = 0;
        while (exp1.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (exp1.size() != 0) begin
            tmo(name);
            exp1.delete();
        end
    endtask

    task automatic drain2(input string name);
        int n = 0;
        while (exp2.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (exp2.size() != 0) begin
            tmo(name);
            exp2.delete();
        end
    endtask

    // Manual one-cycle icache for dut2: wait for a request, check its address, answer it.
    task automatic serve2(input logic [31:0] exp_addr);
        int n = 0;
        logic [31:0] a;
        @(negedge clk);
        while (!bus2.icache_req_valid_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus2.icache_req_valid_out) tmo("dut2 request wait");
        a = bus2.icache_req_addr_out;
        chk("dut2 req addr", {32'h0, a}, {32'h0, exp_addr});
        @(posedge clk);
        #1;
        bus2.icache_resp_valid_in = 1'b1;
        bus2.icache_resp_instr_in = ins_of(a);
        @(posedge clk);
        #1;
        bus2.icache_resp_valid_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst1 = 1'b1;
        rst2 = 1'b1;
        bus1.rdy_in = 1'b1; bus1.icache_req_ready_in = 1'b1; bus1.issue_ready_in = 1'b0;
        bus1.flush_in = 1'b0; bus1.flush_pc_in = '0;
        bus2.rdy_in = 1'b1; bus2.icache_req_ready_in = 1'b1; bus2.issue_ready_in = 1'b0;
        bus2.flush_in = 1'b0; bus2.flush_pc_in = '0;
        bus2.icache_resp_valid_in = 1'b0; bus2.icache_resp_instr_in = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_valid", {63'h0, bus1.icache_req_valid_out}, 64'h0);
        chk("rst req_addr", {32'h0, bus1.icache_req_addr_out}, 64'h0);
        chk("rst issue_valid", {63'h0, bus1.issue_valid_out}, 64'h0);
        chk("rst issue_pc", {32'h0, bus1.issue_pc_out}, 64'h0);
        chk("rst issue_instr", {32'h0, bus1.issue_instr_out}, 64'h0);
        chk("rst count", {61'h0, bus1.count_out}, 64'h0);
        @(negedge clk);
        rst1 = 1'b0;

        // Fill to DEPTH with issue stalled.
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("full count", {61'h0, bus1.count_out}, 64'd4);
        chk("full head pc", {32'h0, bus1.issue_pc_out}, 64'h0);
        chk("full head instr", {32'h0, bus1.issue_instr_out}, {32'h0, ins_of(32'h0)});
        chk("full next addr", {32'h0, bus1.icache_req_addr_out}, 64'h10);
        for (int i = 0; i < 8; i++) begin
            chk("full no req", {63'h0, bus1.icache_req_valid_out}, 64'h0);
            @(negedge clk);
        end

        // Steady issue: sixteen sequential PCs in order.
        for (int i = 0; i < 16; i++) push1(32'(i * 4));
        drain1("stream drain");
        repeat (20) @(posedge clk);

        // Flush while waiting on the icache; stale response lands the following cycle.
        resp_delay = 2;
        push1(32'h40);
        drain1("pre-flush drain");
        wait_req1("pre-flush req");
        chk("pre-flush req addr", {32'h0, bus1.icache_req_addr_out}, 64'h50);
        @(posedge clk);
        #1;
        bus1.flush_in = 1'b1;
        bus1.flush_pc_in = 32'h1000;
        @(posedge clk);
        #1;
        bus1.flush_in = 1'b0;
        resp_delay = 1;
        chk("flush1 count", {61'h0, bus1.count_out}, 64'h0);
        chk("flush1 issue_valid", {63'h0, bus1.issue_valid_out}, 64'h0);
        wait_req1("flush1 req");
        chk("flush1 req addr", {32'h0, bus1.icache_req_addr_out}, 64'h1000);
        push1(32'h1000); push1(32'h1004); push1(32'h1008);
        drain1("flush1 drain");
        repeat (20) @(posedge clk);

        // Flush of an unaccepted request with a misaligned target.
        bus1.icache_req_ready_in = 1'b0;
        push1(32'h100C);
        drain1("flush2 pre drain");
        wait_req1("flush2 pre req");
        chk("flush2 pre addr", {32'h0, bus1.icache_req_addr_out}, 64'h101C);
        @(posedge clk);
        #1;
        bus1.flush_in = 1'b1;
        bus1.flush_pc_in = 32'h2003;
        @(posedge clk);
        #1;
        bus1.flush_in = 1'b0;
        chk("flush2 req_valid drop", {63'h0, bus1.icache_req_valid_out}, 64'h0);
        chk("flush2 count", {61'h0, bus1.count_out}, 64'h0);
        wait_req1("flush2 req");
        chk("flush2 req addr", {32'h0, bus1.icache_req_addr_out}, 64'h2000);

        // Freeze with a request pending and the head valid.
        bus1.icache_req_ready_in = 1'b1;
        n = 0;
        @(posedge clk);
        #1;
        while (bus1.count_out != 3'd2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus1.count_out != 3'd2) tmo("freeze setup");
        bus1.icache_req_ready_in = 1'b0;
        @(negedge clk);
        bus1.rdy_in = 1'b0;
        bus1.icache_req_ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("freeze req_valid", {63'h0, bus1.icache_req_valid_out}, 64'h1);
            chk("freeze req_addr", {32'h0, bus1.icache_req_addr_out}, 64'h2008);
            chk("freeze count", {61'h0, bus1.count_out}, 64'd2);
            chk("freeze head pc", {32'h0, bus1.issue_pc_out}, 64'h2000);
            chk("freeze head instr", {32'h0, bus1.issue_instr_out}, {32'h0, ins_of(32'h2000)});
        end
        bus1.rdy_in = 1'b1;
        push1(32'h2000); push1(32'h2004); push1(32'h2008); push1(32'h200C);
        drain1("freeze resume drain");

        // Second instance: reset PC at the top of the address space.
        chk("dut2 rst addr", {32'h0, bus2.icache_req_addr_out}, 64'hFFFF_FFFC);
        chk("dut2 rst req_valid", {63'h0, bus2.icache_req_valid_out}, 64'h0);
        @(negedge clk);
        rst2 = 1'b0;
        serve2(32'hFFFF_FFFC);
        serve2(32'h0000_0000);
        @(negedge clk);
        chk("dut2 count", {61'h0, bus2.count_out}, 64'd2);
        chk("dut2 head pc", {32'h0, bus2.issue_pc_out}, 64'hFFFF_FFFC);
        chk("dut2 req addr wrap", {32'h0, bus2.icache_req_addr_out}, 64'h4);
        // Request for 0x4 is accepted on this edge; reset lands mid-WAIT.
        @(posedge clk);
        #2;
        rst2 = 1'b1;
        #1;
        chk("dut2 async req_valid", {63'h0, bus2.icache_req_valid_out}, 64'h0);
        chk("dut2 async addr", {32'h0, bus2.icache_req_addr_out}, 64'hFFFF_FFFC);
        chk("dut2 async count", {61'h0, bus2.count_out}, 64'h0);
        chk("dut2 async issue_valid", {63'h0, bus2.issue_valid_out}, 64'h0);
        chk("dut2 async issue_pc", {32'h0, bus2.issue_pc_out}, 64'h0);
        @(negedge clk);
        rst2 = 1'b0;
        serve2(32'hFFFF_FFFC);
        serve2(32'h0000_0000);
        push2(32'hFFFF_FFFC);
        push2(32'h0000_0000);
        drain2("dut2 drain");
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
